// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction ROM port, branch redirect input and the IF_ID handshake.
// IF_ID handshake: a word transfers on a rising edge when if_valid and id_ready are both high.
// Asserting redirect_valid forces if_valid low in that cycle, so no transfer happens.
interface fetch_ctrl_if;
  logic [31:0] rom_addr;
  logic        rom_flush;
  logic [31:0] rom_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        fetch_fault;

  modport master (
    output rom_addr, rom_flush, if_valid, if_inst, if_pc, fetch_fault,
    input  rom_inst, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  rom_addr, rom_flush, if_valid, if_inst, if_pc, fetch_fault,
    output rom_inst, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the pc, reads the combinational ROM and buffers
// fetched words in a 2-entry FIFO toward IF_ID, with redirect and range-fault handling.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_WORDS = 64,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_ctrl_if.master bus,
  output logic [1:0]   o_dbg_state
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  localparam logic [31:0] ROM_WORDS_L = 32'(ROM_WORDS);

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_fault;
  logic [31:0] r_q_pc   [0:1];
  logic [31:0] r_q_inst [0:1];
  logic        r_head;
  logic        r_tail;
  logic [1:0]  r_count;

  logic        w_not_empty;
  logic        w_pop;
  logic        w_can_push;
  logic        w_push;
  logic [31:0] w_pc_next;

  function automatic logic pc_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < ROM_WORDS_L);
  endfunction

  assign w_not_empty = (r_count != 2'd0);
  assign w_pop       = w_not_empty & bus.id_ready & ~bus.redirect_valid;
  assign w_can_push  = (r_count < 2'd2) | w_pop;
  // Only RUN fetches; in RUN the current pc is always a valid target.
  assign w_push      = (r_state == S_RUN) & w_can_push & ~bus.redirect_valid;
  assign w_pc_next   = r_pc + 32'd4;

  assign bus.rom_addr    = r_pc;
  assign bus.rom_flush   = ~w_push;
  assign bus.if_valid    = w_not_empty & ~bus.redirect_valid;
  assign bus.if_inst     = w_not_empty ? r_q_inst[r_head] : NOP_INST;
  assign bus.if_pc       = w_not_empty ? r_q_pc[r_head] : 32'h0;
  assign bus.fetch_fault = r_fault;
  assign o_dbg_state     = r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_PC;
      r_fault <= 1'b0;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
    end else if (r_state == S_BOOT) begin
      if (pc_ok(r_pc)) begin
        r_state <= S_RUN;
      end else begin
        r_state <= S_FAULT;
        r_fault <= 1'b1;
      end
    end else if (bus.redirect_valid) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
      r_pc    <= bus.redirect_pc;
      if (pc_ok(bus.redirect_pc)) begin
        r_state <= S_RUN;
        r_fault <= 1'b0;
      end else begin
        r_state <= S_FAULT;
        r_fault <= 1'b1;
      end
    end else begin
      if (w_push) begin
        r_q_pc[r_tail]   <= r_pc;
        r_q_inst[r_tail] <= bus.rom_inst;
        r_tail           <= ~r_tail;
        r_pc             <= w_pc_next;
        // The word at the last valid address is kept; stop before fetching past it.
        if (!pc_ok(w_pc_next)) begin
          r_state <= S_FAULT;
          r_fault <= 1'b1;
        end
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios then random traffic, compared each cycle
// against a queue-based reference model of the fetch rules.
module tb_fetch_ctrl;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          ROM_WORDS = 64;
  localparam logic [31:0] NOP_INST  = 32'h0000_0013;
  localparam int P_BOOT  = 0;
  localparam int P_RUN   = 1;
  localparam int P_FAULT = 2;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         n_checks;
  int         n_fail;

  fetch_ctrl_if bus ();

  fetch_ctrl #(
    .RESET_PC (RESET_PC),
    .ROM_WORDS(ROM_WORDS),
    .NOP_INST (NOP_INST)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < 32'(ROM_WORDS * 4));
  endfunction

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return addr_ok(a) ? 32'hA000_0000 + (a / 4) : 32'hBAD0_0000;
  endfunction

  // instruction ROM: combinational, returns NOP while flushed
  always_comb bus.rom_inst = bus.rom_flush ? NOP_INST : rom_word(bus.rom_addr);

  // reference model
  logic [63:0] exp_q[$];
  int          m_phase;
  logic [31:0] m_pc;
  logic        m_fault;
  bit          m_known;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at negedge, check, then advance the model at posedge.
  task automatic cycle(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc);
    logic        e_pop;
    logic        e_push;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    rst_n              = rst;
    bus.id_ready       = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    #1;
    e_pop  = (exp_q.size() > 0) && rdy && !rv;
    e_push = (m_phase == P_RUN) && !rv && ((exp_q.size() < 2) || e_pop);
    e_inst = NOP_INST;
    e_pc   = 32'h0;
    if (exp_q.size() > 0) begin
      e_inst = exp_q[0][31:0];
      e_pc   = exp_q[0][63:32];
    end
    if (m_known) begin
      check("if_valid", 32'(bus.if_valid), 32'((exp_q.size() > 0) && !rv));
      check("if_inst", bus.if_inst, e_inst);
      check("if_pc", bus.if_pc, e_pc);
      check("rom_addr", bus.rom_addr, m_pc);
      check("rom_flush", 32'(bus.rom_flush), 32'(!e_push));
      check("fetch_fault", 32'(bus.fetch_fault), 32'(m_fault));
    end
    @(posedge clk);
    if (!rst) begin
      m_phase = P_BOOT;
      m_pc    = RESET_PC;
      m_fault = 1'b0;
      exp_q.delete();
      m_known = 1'b1;
    end else if (m_known) begin
      if (m_phase == P_BOOT) begin
        if (addr_ok(RESET_PC)) m_phase = P_RUN;
        else begin
          m_phase = P_FAULT;
          m_fault = 1'b1;
        end
      end else if (rv) begin
        exp_q.delete();
        m_pc = rpc;
        if (addr_ok(rpc)) begin
          m_phase = P_RUN;
          m_fault = 1'b0;
        end else begin
          m_phase = P_FAULT;
          m_fault = 1'b1;
        end
      end else begin
        if (e_pop) void'(exp_q.pop_front());
        if (e_push) begin
          exp_q.push_back({m_pc, rom_word(m_pc)});
          m_pc = m_pc + 32'd4;
          if (!addr_ok(m_pc)) begin
            m_phase = P_FAULT;
            m_fault = 1'b1;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    case ($urandom_range(0, 5))
      0, 1, 2: t = 32'($urandom_range(0, 63)) * 4;
      3:       t = 32'($urandom_range(58, 70)) * 4;
      4:       t = 32'($urandom_range(0, 255));
      default: t = 32'hFFFF_FFFC;
    endcase
    return t;
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_known  = 1'b0;
    m_phase  = P_BOOT;
    m_pc     = RESET_PC;
    m_fault  = 1'b0;
    rst_n              = 1'b0;
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    @(negedge clk);

    // reset, then streaming fetch from RESET_PC
    repeat (2) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (12) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // stall with head at pc=8, then release
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // redirect while the queue is full
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h40);
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // run off the end of the ROM, drain, then recover
    cycle(1'b1, 1'b1, 1'b1, 32'hF0);
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (8) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0);
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // misaligned redirect, then a same-cycle reset and redirect
    cycle(1'b1, 1'b1, 1'b1, 32'h6);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 32'h20);
    repeat (5) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      cycle(1'($urandom_range(0, 199) != 0),
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 9) == 0),
            rand_target());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
